multi_channel_producer: RTL
===========================

Name: multi_channel_producer

Overview:
- Parametrised stimulus producer that drives NUM_CH independent pipeline channels with interleaved sequence numbers. Channel i emits i, i+STRIDE, i+2*STRIDE, and so on.
- Each channel has a proper valid/stall handshake: a beat is held, not dropped, while its consumer stalls.
- Each channel raises a periodic flush marker on the last beat of every group of FLUSH_PERIOD beats.
- Runs are bounded by a programmable beat count and controlled by a start/stop FSM. The block sits at the head of the multi-pipeline test harness.

Parameters:
- NUM_CH, 2, number of output channels (1..16).
- DATA_W, 32, width of each channel's data word.
- STRIDE, NUM_CH, increment applied to a channel's counter per accepted beat.
- FLUSH_PERIOD, 128, beats per flush group (power of two, >= 2).
- CNT_W, 16, width of the beat-count configuration and the per-channel beat counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  request early termination; sampled only in RUN.
- cfg_count  in  CNT_W  beats per channel for the run; 0 = unlimited. Captured on start.
- in_stall  in  NUM_CH  per-channel consumer stall; bit i belongs to channel i.
- out_data  out  NUM_CH*DATA_W  flattened data; channel i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  NUM_CH  per-channel valid.
- out_flush  out  NUM_CH  per-channel flush marker, qualified by out_valid.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when a run completes.

Behaviour:
- Clocking and reset:
  - Clock is clk. Reset is reset, asynchronous, active-high.
  - On reset: state=IDLE; out_valid=0, out_flush=0, busy=0, done=0.
  - On reset: counter[i]=i (truncated to DATA_W); out_data[i]=0; beat counters cleared; captured count cleared.
- Reset mid-run aborts the run immediately with no done pulse.
- Handshake:
  - A beat on channel i is accepted in a cycle where out_valid[i]=1 and in_stall[i]=0.
  - While out_valid[i]=1 and in_stall[i]=1, out_data[i], out_flush[i] and out_valid[i] hold stable.
  - in_stall[i] has no effect while out_valid[i]=0.
- Launch rule (RUN only): channel i launches a beat at the next edge when two conditions both hold:
  - (a) out_valid[i]=0, or its current beat is accepted this cycle;
  - (b) issued[i] < cap, or cap=0.
- On launch:
  - out_data[i] <= counter[i] and counter[i] <= counter[i]+STRIDE, with wrap modulo 2^DATA_W.
  - out_flush[i] <= (issued[i] mod FLUSH_PERIOD == FLUSH_PERIOD-1).
  - issued[i] increments, saturating at 2^CNT_W-1.
- If neither launch nor hold applies, out_valid[i] <= 0 and out_flush[i] <= 0. Throughput is 1 beat/cycle/channel with no stalls.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN. In the same edge: cap <= cfg_count, issued[*] <= 0, counter[i] <= i.
  - First valid appears 1 cycle after RUN is entered, i.e. 2 edges after start is sampled.
- RUN:
  - stop=1 -> DRAIN. No launch occurs on that edge.
  - When every channel has issued[i]==cap, cap!=0, and no out_valid is set -> DONE.
  - If start and stop are high together while IDLE, stop is ignored.
- DRAIN:
  - No new launches. Pending valid beats stay held until accepted.
  - When all out_valid=0 -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- busy = (state==RUN or state==DRAIN), decoded from registered state.
- cap=0 with no stop runs forever. Counters wrap silently.
- start asserted outside IDLE is ignored.
- cfg_count changes after capture have no effect on the current run.

Test Plan:
- Free run: NUM_CH=2, cfg_count=4, no stalls, start pulse -> ch0 data 0,2,4,6 and ch1 data 1,3,5,7 on consecutive cycles; done pulses once, 1 cycle after the last beat is accepted; busy then falls.
- Stall hold: ch0 stalled for 3 cycles while presenting data 4 -> out_data[0]=4 and out_valid[0]=1 held all 3 cycles; data 6 follows the cycle after stall drops; ch1 sequence unaffected.
- Flush marker: FLUSH_PERIOD=4, cfg_count=8 -> out_flush high only on beats 3 and 7 (ch0 data 6 and 14; ch1 data 7 and 15).
- Early stop: cfg_count=0, stop asserted after 5 beats while ch1 is stalled -> no further launches; the held ch1 beat is still delivered once the stall drops; then done.
- Wrap: DATA_W=4, STRIDE=2, cfg_count=10 -> ch0 data 0,2,...,14,0,2.
- Async reset mid-run with out_valid=11 -> all outputs 0 immediately with no clock edge; no done pulse; the next start restarts ch0 at 0 and ch1 at 1.

Source files
------------

// File: rtl/multi_channel_producer_if.sv
// Per-channel output bus of the multi-channel producer: flattened data words,
// valid and flush markers travelling downstream, stall travelling upstream.
interface multi_channel_producer_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32
);
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_flush;
  logic [NUM_CH-1:0]        in_stall;

  modport master (
    output out_data,
    output out_valid,
    output out_flush,
    input  in_stall
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_flush,
    output in_stall
  );
endinterface

// File: rtl/multi_channel_producer.sv
// Stimulus producer for the multi-pipeline harness. Each channel i emits the
// sequence i, i+STRIDE, i+2*STRIDE, ... under a valid/stall handshake, marks
// the last beat of every FLUSH_PERIOD-beat group, and a start/stop FSM bounds
// each run to cfg_count beats per channel (0 = unlimited).
module multi_channel_producer #(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 32,
  parameter int STRIDE       = NUM_CH,
  parameter int FLUSH_PERIOD = 128,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [CNT_W-1:0]         cfg_count,
  multi_channel_producer_if.master bus,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  ZERO_CNT   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONE_CNT    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  ISSUED_MAX = {CNT_W{1'b1}};
  // FLUSH_PERIOD is a power of two, so "issued mod period" is a mask.
  localparam logic [CNT_W-1:0]  FLUSH_MASK = CNT_W'(FLUSH_PERIOD - 1);
  localparam logic [DATA_W-1:0] STRIDE_W   = DATA_W'(STRIDE);
  localparam logic [DATA_W-1:0] ZERO_DATA  = {DATA_W{1'b0}};
  localparam logic [NUM_CH-1:0] ZERO_CH    = {NUM_CH{1'b0}};

  state_t            state_r;
  state_t            state_next_s;
  logic              busy_r;
  logic              done_r;
  logic [CNT_W-1:0]  cap_r;
  logic [DATA_W-1:0] counter_r [NUM_CH];
  logic [DATA_W-1:0] data_r    [NUM_CH];
  logic [CNT_W-1:0]  issued_r  [NUM_CH];
  logic [NUM_CH-1:0] valid_r;
  logic [NUM_CH-1:0] flush_r;
  logic [NUM_CH-1:0] launch_s;
  logic [NUM_CH-1:0] hold_s;
  logic              all_issued_s;
  logic              run_start_s;

  assign run_start_s = (state_r == ST_IDLE) && start;

  // Per-channel hold (stalled beat) and launch (free slot, budget left, RUN) decisions
  always_comb begin
    launch_s = ZERO_CH;
    hold_s   = ZERO_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      hold_s[i] = valid_r[i] & bus.in_stall[i];
      if ((state_r == ST_RUN) && !stop && !hold_s[i] &&
          ((cap_r == ZERO_CNT) || (issued_r[i] < cap_r))) begin
        launch_s[i] = 1'b1;
      end else begin
        launch_s[i] = 1'b0;
      end
    end
  end

  // A bounded run is complete once every channel has issued exactly cap beats
  always_comb begin
    all_issued_s = (cap_r != ZERO_CNT);
    for (int i = 0; i < NUM_CH; i++) begin
      all_issued_s = all_issued_s & (issued_r[i] == cap_r);
    end
  end

  // Run-control FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next_s = ST_DRAIN;
        end else if (all_issued_s && (valid_r == ZERO_CH)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (valid_r == ZERO_CH) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state plus busy/done flops, which track the state register exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Beat budget is captured once at start so later cfg_count changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_r <= ZERO_CNT;
    end else if (run_start_s) begin
      cap_r <= cfg_count;
    end else begin
      cap_r <= cap_r;
    end
  end

  // Channel sequence counters, issued-beat counters and the registered beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        counter_r[i] <= DATA_W'(i);
        data_r[i]    <= ZERO_DATA;
        issued_r[i]  <= ZERO_CNT;
      end
      valid_r <= ZERO_CH;
      flush_r <= ZERO_CH;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (run_start_s) begin
          counter_r[i] <= DATA_W'(i);
          issued_r[i]  <= ZERO_CNT;
        end else if (launch_s[i]) begin
          counter_r[i] <= counter_r[i] + STRIDE_W;
          if (issued_r[i] != ISSUED_MAX) begin
            issued_r[i] <= issued_r[i] + ONE_CNT;
          end
        end

        if (launch_s[i]) begin
          data_r[i]  <= counter_r[i];
          flush_r[i] <= ((issued_r[i] & FLUSH_MASK) == FLUSH_MASK);
          valid_r[i] <= 1'b1;
        end else if (!hold_s[i]) begin
          valid_r[i] <= 1'b0;
          flush_r[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.out_data[g*DATA_W +: DATA_W] = data_r[g];
  end

  assign bus.out_valid = valid_r;
  assign bus.out_flush = flush_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule
